muldiv_unit: RTL and testbench

Iterative multiply/divide unit with HI/LO registers, the responder to the EX stage for MULT, MULTU, DIV, DIVU, MTHI and MTLO. EX issues an operation with a one-cycle `start` pulse and operands already forwarded. The unit iterates radix-2 for 32 cycles and then writes HI/LO. The hazard logic in ID stalls MFHI/MFLO and new mult/div issue while `busy` is high.

---
 rtl/muldiv_unit.sv | 143 ++++++++++++++
 tb/tb_muldiv_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers.
// Takes 32 CALC cycles plus one FIX cycle; abort cancels without touching HI/LO.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wr_data,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // state | meaning
  // IDLE  | waiting for start; MTHI/MTLO allowed
  // CALC  | 32 shift-add / restoring-divide iterations
  // FIX   | sign fixup, write HI/LO, pulse done
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t      state, state_nxt;
  logic [4:0]  count;
  logic        is_div, neg_res, neg_rem, div_zero;
  logic [31:0] orig_a, mag_a, mag_b, shreg;
  logic [63:0] prod;
  logic [32:0] rem;

  logic        accept, is_signed, sign_a, sign_b;
  logic [31:0] abs_a, abs_b;
  logic [32:0] div_shift, div_sub;
  logic        div_ge;
  logic [63:0] mul_add, prod_fix;
  logic [31:0] quo_fix, rem_fix;

  assign accept    = (state == S_IDLE) && start && !abort;
  assign is_signed = ~op[0];
  assign sign_a    = is_signed & op_a[31];
  assign sign_b    = is_signed & op_b[31];
  assign abs_a     = sign_a ? (32'd0 - op_a) : op_a;
  assign abs_b     = sign_b ? (32'd0 - op_b) : op_b;

  // The quotient bits shift into shreg from the right while dividend bits leave at the top.
  assign div_shift = {rem[31:0], shreg[31]};
  assign div_ge    = (div_shift >= {1'b0, mag_b});
  assign div_sub   = div_shift - {1'b0, mag_b};
  assign mul_add   = prod + (shreg[0] ? ({32'd0, mag_a} << count) : 64'd0);

  assign prod_fix  = neg_res ? (64'd0 - prod) : prod;
  assign quo_fix   = neg_res ? (32'd0 - shreg) : shreg;
  assign rem_fix   = neg_rem ? (32'd0 - rem[31:0]) : rem[31:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_CALC;
      S_CALC: begin
        if (abort)               state_nxt = S_IDLE;
        else if (count == 5'd31) state_nxt = S_FIX;
      end
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 5'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      busy <= (state_nxt != S_IDLE);
      done <= (state == S_FIX) && !abort;
      if (state == S_CALC && !abort) count <= count + 5'd1;
      else                           count <= 5'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      orig_a   <= 32'd0;
      mag_a    <= 32'd0;
      mag_b    <= 32'd0;
      shreg    <= 32'd0;
      prod     <= 64'd0;
      rem      <= 33'd0;
    end else if (accept) begin
      is_div   <= op[1];
      neg_res  <= sign_a ^ sign_b;
      neg_rem  <= sign_a;
      div_zero <= op[1] && (op_b == 32'd0);
      orig_a   <= op_a;
      mag_a    <= abs_a;
      mag_b    <= abs_b;
      shreg    <= op[1] ? abs_a : abs_b;
      prod     <= 64'd0;
      rem      <= 33'd0;
    end else if (state == S_CALC && !abort) begin
      if (is_div) begin
        rem   <= div_ge ? div_sub : div_shift;
        shreg <= {shreg[30:0], div_ge};
      end else begin
        prod  <= mul_add;
        shreg <= {1'b0, shreg[31:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (state == S_FIX && !abort) begin
      if (is_div && div_zero) begin
        hi <= orig_a;
        lo <= 32'hFFFF_FFFF;
      end else if (is_div) begin
        hi <= rem_fix;
        lo <= quo_fix;
      end else begin
        hi <= prod_fix[63:32];
        lo <= prod_fix[31:0];
      end
    end else if (state == S_IDLE && !accept) begin
      if (mthi) hi <= wr_data;
      if (mtlo) lo <= wr_data;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n, start, mthi, mtlo, abort;
  logic [1:0]  op;
  logic [31:0] op_a, op_b, wr_data;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
    .mthi(mthi), .mtlo(mtlo), .wr_data(wr_data), .abort(abort),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // {hi, lo} from plain integer arithmetic on the architectural rules
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    case (o)
      2'b00: begin q = sa * sb; return q; end
      2'b01: begin p = {32'd0, a} * {32'd0, b}; return p; end
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic mt_write(input logic whi, input logic wlo, input logic [31:0] d);
    mthi = whi; mtlo = wlo; wr_data = d;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    if (whi) exp_hi = d;
    if (wlo) exp_lo = d;
    chk("mt_hi", hi, exp_hi);
    chk("mt_lo", lo, exp_lo);
  endtask

  // Index i = sample taken on the falling edge after the i-th rising edge following issue.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int abort_at, input int restart_at,
                        input int mthi_at);
    int busy_cnt, done_cnt, done_at, exp_busy;
    logic [63:0] r;
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    op = o; op_a = a; op_b = b; start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_at = i; end
      start = (i == restart_at);
      if (i == restart_at) begin op = ~o; op_a = $urandom; op_b = $urandom; end
      mthi  = (i == mthi_at);
      wr_data = $urandom;
      abort = (i == abort_at);
      @(negedge clk);
    end
    start = 1'b0; mthi = 1'b0; abort = 1'b0;
    if (abort_at < 0) begin
      r = ref_result(o, a, b);
      exp_hi = r[63:32];
      exp_lo = r[31:0];
      exp_busy = 33;
    end else begin
      exp_busy = abort_at + 1;
    end
    chk({tag, "_busy_cycles"}, busy_cnt, exp_busy);
    chk({tag, "_done_pulses"}, done_cnt, (abort_at < 0) ? 1 : 0);
    if (abort_at < 0) chk({tag, "_done_at"}, done_at, 33);
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'd0;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; abort = 1'b0;
    op = 2'b00; op_a = 32'd0; op_b = 32'd0; wr_data = 32'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, -1);
    chk("multu_max_hi_lit", hi, 32'hFFFF_FFFE);
    chk("multu_max_lo_lit", lo, 32'h0000_0001);
    run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, -1, -1, -1);
    chk("mult_neg_lit", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, -1, -1, -1);
    chk("div_neg_lit", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op("div_wrap", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, -1);
    chk("div_wrap_lit", {hi, lo}, {32'd0, 32'h8000_0000});
    run_op("divu_zero", 2'b11, 32'h1234, 32'd0, -1, -1, -1);
    chk("divu_zero_lit", {hi, lo}, {32'h1234, 32'hFFFF_FFFF});

    mt_write(1'b0, 1'b1, 32'hAAAA_5555);
    run_op("multu_5x6", 2'b01, 32'd5, 32'd6, -1, 10, 12);
    chk("multu_5x6_lit", {hi, lo}, {32'd0, 32'h1E});

    mt_write(1'b1, 1'b1, 32'h0BAD_F00D);
    run_op("abort10", 2'b01, 32'd123, 32'd456, 10, -1, -1);
    run_op("abort_fix", 2'b10, 32'd99, 32'd7, 32, -1, -1);

    // start and mthi in the same idle cycle: start wins
    mthi = 1'b1; wr_data = 32'h5A5A_5A5A;
    run_op("start_vs_mthi", 2'b11, 32'd100, 32'd9, -1, -1, -1);

    for (int n = 0; n < 24; n++) begin
      logic [31:0] a, b;
      int ab;
      a = pick_operand();
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : pick_operand();
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 32)) : -1;
      if ($urandom_range(0, 3) == 0)
        mt_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      run_op("rand", 2'($urandom_range(0, 3)), a, b, ab, -1, -1);
    end

    // asynchronous reset in the middle of an operation
    op = 2'b00; op_a = 32'h7; op_b = 32'h9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_hi = 32'd0; exp_lo = 32'd0;
    repeat (40) @(negedge clk);
    chk("postrst_done", done, 1'b0);
    chk("postrst_hilo", {hi, lo}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
